wb_rotenc: RTL
==============

# wb_rotenc

Wishbone slave that decodes the Spartan-3E starter-kit rotary encoder (`rot[2:0]`) into a signed position counter with sticky step and press events plus a level interrupt. It occupies interconnect slave 6 (`s6_addr` 15'h7003, base 0xE0060000) alongside uart0, timer0 and gpio0. It drives one `intr_n` bit in the system interrupt vector.

## Interface
- `clk_freq`, default 50000000: system clock in Hz.
- `debounce_us`, default 1000: required input stability time in µs. `debounce_cycles` = `clk_freq`/1000000 × `debounce_us`. This value must be at least 1 and at most 2^20−1.
- `clk` in, 1 bit: system clock; all logic is on the rising edge.
- `reset` in, 1 bit: asynchronous, active-high reset.
- `wb_adr_i` in, 32 bits: Wishbone address; only [3:2] is decoded.
- `wb_dat_i` in, 32 bits: write data.
- `wb_dat_o` out, 32 bits: read data, registered.
- `wb_sel_i` in, 4 bits: byte selects.
- `wb_stb_i`, `wb_cyc_i`, `wb_we_i` in, 1 bit each: Wishbone strobe, cycle and write enable.
- `wb_ack_o` out, 1 bit: acknowledge.
- `intr` out, 1 bit: active-high level interrupt.
- `rot` in, 3 bits: asynchronous pins; [0] = A, [1] = B, [2] = centre push.

## Operation
- **Input conditioning**
  - Each `rot` bit passes through a 2-flop synchronizer, then a 20-bit debounce counter.
  - The debounced bit takes the synchronized value once that value has differed from it for `debounce_cycles` consecutive clocks.
  - Any return to the old value resets the counter to 0.
  - Debounced bits reset to 0.
- **Quadrature FSM**
  - State = debounced {A,B}. The CW sequence is 00→01→11→10→00; CCW is the reverse.
  - A 3-bit signed sub-count `sub` takes +1 on each CW transition and −1 on each CCW transition.
  - If both bits change on the same cycle: set `STATUS.err`, leave `sub` unchanged, and adopt the new state.
  - On entry to state 00:
    - `sub` = +4: POSITION +1, set `STATUS.cw`.
    - `sub` = −4: POSITION −1, set `STATUS.ccw`.
    - In every case, `sub` is cleared to 0. A partial turn that backs out yields no step.
  - Steps update POSITION only when `CONTROL.en` = 1. Sticky bits are set regardless of `CONTROL.en`.
- **Registers** (offset = `wb_adr_i[3:2]`×4)
  - 0x0 POSITION, read/write, 32-bit two's complement. Writes honour every `wb_sel_i` byte. Wraps freely: 0x7FFFFFFF+1 = 0x80000000, 0x00000000−1 = 0xFFFFFFFF.
  - 0x4 STATUS. Bit0 `cw`, bit1 `ccw`, bit2 `press`, bit4 `err` are sticky and write-1-to-clear (W1C) under `wb_sel_i[0]`. Bit3 is the debounced centre level (read-only). Other bits read 0.
  - 0x8 CONTROL, read/write under `wb_sel_i[0]`. Bit0 `en`, bit1 `irq_step`, bit2 `irq_press`. Reset value 0x1.
  - 0xC: reads 0; writes are ignored.
- **Press event:** `press` is set on a debounced centre rising edge (0→1).
- **Interrupt:** `intr` is registered, equal to (`irq_step` & (`cw`|`ccw`)) | (`irq_press` & `press`).
- **Simultaneous events**
  - A POSITION write in the same cycle as a step: the write wins, and the step's sticky bit is still set.
  - A W1C write in the same cycle as a new event on the same bit: the bit stays 1.
- **Reset mid-operation:** all state clears asynchronously. The FSM restarts from debounced state 00, and any pins not at 00 are re-acquired through the debouncer without generating a step.

## Timing
- **Reset values:** `wb_dat_o` = 0, `wb_ack_o` = 0, `intr` = 0. POSITION = 0, STATUS = 0, CONTROL = 0x1, `sub` = 0.
- **Wishbone:** `wb_ack_o` <= `wb_stb_i` & `wb_cyc_i` & ~`wb_ack_o`.
  - The result is a single-cycle ack, one clock after the strobe, so back-to-back cycles take 2 clocks each.
  - Read data is valid in the ack cycle.
  - A write takes effect on the ack edge.
- **Pin-to-register latency**
  - A pin edge reaches its debounced bit `debounce_cycles`+2 clocks later.
  - POSITION and the sticky bits update 1 clock after that.
  - `intr` updates 1 clock after the sticky bits.
- A read in the same cycle as an update returns the pre-update value.

## Configuration
- `ROTENC_PRESS_EN` defined: the centre channel is compiled in (synchronizer, debouncer, edge detect, STATUS bits 2/3, CONTROL bit 2).
- Not defined: `rot[2]` is ignored. STATUS bits 2/3 and CONTROL bit 2 read 0 and ignore writes. The press term is removed from `intr`.

## Test plan
All scenarios use `clk_freq`=1000000 and `debounce_us`=4 (`debounce_cycles`=4).
- **Reset:** read 0x0/0x4/0x8 → 0x0, 0x0, 0x1; `intr`=0; each `wb_ack_o` lasts exactly 1 cycle.
- **Full CW and CCW detents:** drive {A,B} 00→01→11→10→00 with 10 clocks per state → POSITION=1, STATUS=0x1, and the update lands exactly 7 clocks after the final 00 pin edge. Reverse sequence → POSITION=0, STATUS=0x3.
- **Bounce and back-out:** 2-clock glitch pulses on A → no change. Sequence 00→01→11→01→00 → POSITION unchanged, `sub` cleared. 00→11 in one step → STATUS bit4 set.
- **Wrap and write collision:**
  - Write POSITION=0x7FFFFFFF, then one CW detent → 0x80000000.
  - Write POSITION=0x5 on the same cycle as a step commit → reads 0x5 with `cw` set.
  - W1C in the same cycle as a new `cw` → `cw` stays 1.
- **Interrupt:** CONTROL=0x3 plus one CW step → `intr`=1. Write 0x1 to STATUS → `intr`=0 two clocks later. CONTROL=0x2 → steps set sticky bits but POSITION is unchanged.
- **Press** (`ROTENC_PRESS_EN`): centre held 10 clocks with CONTROL=0x4 → STATUS=0xC and `intr`=1. Without the macro → STATUS bits 2/3 stay 0 and `intr`=0.

Source files
------------

// File: rtl/wb_rotenc.sv
// wb_rotenc: Wishbone slave decoding a quadrature rotary encoder (A/B plus
// optional centre push) into a signed position counter with sticky events
// and a level interrupt.
//
// Parameters:
//   clk_freq     system clock in Hz
//   debounce_us  required input stability time in microseconds
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   wb_adr_i/dat_i/sel_i       Wishbone address ([3:2] decoded), write data, byte selects
//   wb_stb_i/cyc_i/we_i        Wishbone strobe, cycle, write enable
//   wb_dat_o, wb_ack_o         registered read data, single-cycle acknowledge
//   intr                       registered active-high level interrupt
//   rot                        async pins: [0]=A, [1]=B, [2]=centre push
// Register map (offset = adr[3:2]*4):
//   0x0 POSITION  0x4 STATUS (W1C sticky)  0x8 CONTROL  0xC reads 0
// Build option:
//   ROTENC_PRESS_EN  compiles in the centre-push channel.
module wb_rotenc #(
  parameter int clk_freq    = 50000000,
  parameter int debounce_us = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic [2:0]  rot
);

  localparam int          DB_CYC  = (clk_freq / 1000000) * debounce_us;
  localparam logic [19:0] DB_LAST = 20'(DB_CYC - 1);

`ifdef ROTENC_PRESS_EN
  localparam int NCH       = 3;
  localparam bit HAS_PRESS = 1'b1;
`else
  localparam int NCH       = 2;
  localparam bit HAS_PRESS = 1'b0;
  wire unused_rot = rot[2];
`endif

  wire unused_adr = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0]};

  // Synchronizer + debouncer per channel
  logic [NCH-1:0]       sync1, sync2, deb;
  logic [NCH-1:0][19:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= rot[NCH-1:0];
      sync2 <= sync1;
      for (int i = 0; i < NCH; i++) begin
        if (sync2[i] == deb[i])       cnt[i] <= '0;
        else if (cnt[i] == DB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else                      cnt[i] <= cnt[i] + 20'd1;
      end
    end
  end

  // Quadrature decode: ab_q is the previously seen debounced state
  logic [1:0] ab, ab_q;
  logic [2:0] sub, sub_inc;
  logic       chg, mv_cw, mv_ccw, mv_err, enter0, step_cw, step_ccw;

  assign ab = {deb[0], deb[1]};

  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    chg     = (ab != ab_q);
    mv_cw   = chg && (ab == cw_next(ab_q));
    mv_ccw  = chg && (ab_q == cw_next(ab));
    // Single-bit moves are always CW or CCW, so anything else is a double change
    mv_err  = chg && !mv_cw && !mv_ccw;
    sub_inc = sub;
    if (mv_cw)       sub_inc = sub + 3'd1;
    else if (mv_ccw) sub_inc = sub - 3'd1;
    enter0  = chg && (ab == 2'b00);
    // 3'b100 is +4 when reached clockwise and -4 when reached counter-clockwise
    step_cw  = enter0 && mv_cw  && (sub_inc == 3'b100);
    step_ccw = enter0 && mv_ccw && (sub_inc == 3'b100);
  end

  // Centre channel
  logic press_ev, c_lvl;
`ifdef ROTENC_PRESS_EN
  logic c_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) c_q <= 1'b0;
    else       c_q <= deb[2];
  end
  assign press_ev = deb[2] & ~c_q;
  assign c_lvl    = deb[2];
`else
  assign press_ev = 1'b0;
  assign c_lvl    = 1'b0;
`endif

  // Registers and bus
  logic [31:0] position, rdata;
  logic        st_cw, st_ccw, st_press, st_err;
  logic        ctl_en, ctl_step, ctl_press;
  logic        acc, wr_pos, wr_st, wr_ctl;
  logic [4:0]  clr;

  assign acc    = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr_pos = acc & wb_we_i & (wb_adr_i[3:2] == 2'd0);
  assign wr_st  = acc & wb_we_i & (wb_adr_i[3:2] == 2'd1) & wb_sel_i[0];
  assign wr_ctl = acc & wb_we_i & (wb_adr_i[3:2] == 2'd2) & wb_sel_i[0];
  assign clr    = wr_st ? wb_dat_i[4:0] : 5'd0;

  always_comb begin
    rdata = '0;
    case (wb_adr_i[3:2])
      2'd0:    rdata = position;
      2'd1:    rdata = {27'd0, st_err, c_lvl, st_press, st_ccw, st_cw};
      2'd2:    rdata = {29'd0, ctl_press, ctl_step, ctl_en};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ab_q      <= 2'b00;
      sub       <= 3'd0;
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      position  <= '0;
      st_cw     <= 1'b0;
      st_ccw    <= 1'b0;
      st_press  <= 1'b0;
      st_err    <= 1'b0;
      ctl_en    <= 1'b1;
      ctl_step  <= 1'b0;
      ctl_press <= 1'b0;
      intr      <= 1'b0;
    end else begin
      ab_q     <= ab;
      sub      <= enter0 ? 3'd0 : sub_inc;
      wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o;
      if (acc) wb_dat_o <= rdata;

      // A bus write beats a same-cycle step
      if (wr_pos) begin
        for (int b = 0; b < 4; b++)
          if (wb_sel_i[b]) position[8*b +: 8] <= wb_dat_i[8*b +: 8];
      end else if (ctl_en && step_cw)  position <= position + 32'd1;
      else if (ctl_en && step_ccw)     position <= position - 32'd1;

      // New events override a same-cycle clear
      st_cw    <= (st_cw    & ~clr[0]) | step_cw;
      st_ccw   <= (st_ccw   & ~clr[1]) | step_ccw;
      st_press <= (st_press & ~clr[2]) | press_ev;
      st_err   <= (st_err   & ~clr[4]) | mv_err;

      if (wr_ctl) begin
        ctl_en    <= wb_dat_i[0];
        ctl_step  <= wb_dat_i[1];
        ctl_press <= HAS_PRESS & wb_dat_i[2];
      end

      intr <= (ctl_step & (st_cw | st_ccw)) | (ctl_press & st_press);
    end
  end

endmodule
